// File: rtl/vec_buf_pkg.sv
// Shared types and sizing helpers for the QR-datapath vector buffer sequencer.
package vec_buf_pkg;

    localparam int VEC_LEN = 3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_W,
        READ,
        WAIT_R,
        PRESENT
    } state_t;

    // Whole vectors that fit in a buffer FIFO of 2**addr_width elements.
    function automatic int max_vecs(input int addr_width);
        return (2 ** addr_width) / VEC_LEN;
    endfunction

endpackage

// File: rtl/vector_buffer_ctrl_if.sv
// Start/done handshake bus between the sequencer and the three-element vector buffer.
interface vector_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 16
);

    logic                  buf_start_write;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic                  buf_done_load;
    logic                  buf_start_read;
    logic [DATA_WIDTH-1:0] buf_rdata;
    logic                  buf_done_read;

    modport master (
        output buf_start_write, buf_wdata, buf_start_read,
        input  buf_done_load, buf_rdata, buf_done_read
    );

    modport slave (
        input  buf_start_write, buf_wdata, buf_start_read,
        output buf_done_load, buf_rdata, buf_done_read
    );

endinterface

// File: rtl/vec_collector.sv
// Gathers three upstream elements into one vector; holds it (full) until cleared.
module vec_collector
    import vec_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          clear,
    output logic                          full,
    output logic [VEC_LEN*DATA_WIDTH-1:0] vec
);

    logic [1:0] beat;

    assign in_ready = ~full;

    // NOTE: all state here updates with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
            full <= 1'b0;
            // NOTE: element registers are reset too; only three words, and it keeps sim free of X.
            vec  <= '0;
        end else begin
            if (clear)
                full <= 1'b0;
            if (in_valid && !full) begin
                for (int k = 0; k < VEC_LEN; k++)
                    if (beat == 2'(k))
                        vec[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                if (beat == 2'(VEC_LEN - 1)) begin
                    beat <= '0;
                    full <= 1'b1;
                end else begin
                    beat <= beat + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vector_buffer_ctrl.sv
// Sequencer that writes collected vectors into the vector buffer and reads them back on demand.
module vector_buffer_ctrl
    import vec_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [VEC_LEN*DATA_WIDTH-1:0] out_vec,
    vector_buffer_ctrl_if.master          bus,
    output logic [2:0]                    vec_count
);

    localparam logic [2:0] MAX_CNT   = 3'(max_vecs(ADDR_WIDTH));
    localparam logic [2:0] LAST_SLOT = 3'(VEC_LEN + RD_LAT);

    state_t                        state;
    logic [2:0]                    phase_cnt;
    logic [VEC_LEN*DATA_WIDTH-1:0] col_vec;
    logic [VEC_LEN*DATA_WIDTH-1:0] wr_vec;
    logic                          col_full;
    logic                          rd_go;
    logic                          wr_go;

    // Read wins over write so downstream demand is never starved by a steady inflow.
    assign rd_go = (state == IDLE) && (vec_count != 3'd0) && out_ready;
    assign wr_go = (state == IDLE) && !rd_go && col_full && (vec_count < MAX_CNT);

    vec_collector #(.DATA_WIDTH(DATA_WIDTH)) u_collector (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clear    (wr_go),
        .full     (col_full),
        .vec      (col_vec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            phase_cnt           <= '0;
            wr_vec              <= '0;
            out_vec             <= '0;
            out_valid           <= 1'b0;
            vec_count           <= '0;
            bus.buf_start_write <= 1'b0;
            bus.buf_wdata       <= '0;
            bus.buf_start_read  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    if (rd_go) begin
                        state              <= READ;
                        bus.buf_start_read <= 1'b1;
                    end else if (wr_go) begin
                        // Snapshot lets the collector refill while this vector streams out.
                        state               <= WRITE;
                        bus.buf_start_write <= 1'b1;
                        wr_vec              <= col_vec;
                    end
                end
                WRITE: begin
                    for (int k = 0; k < VEC_LEN; k++)
                        if (phase_cnt == 3'(k))
                            bus.buf_wdata <= wr_vec[k*DATA_WIDTH +: DATA_WIDTH];
                    phase_cnt <= phase_cnt + 3'd1;
                    if (phase_cnt == 3'(VEC_LEN - 1))
                        state <= WAIT_W;
                end
                WAIT_W: begin
                    if (bus.buf_done_load) begin
                        state               <= IDLE;
                        bus.buf_start_write <= 1'b0;
                        vec_count           <= vec_count + 3'd1;
                    end
                end
                READ, WAIT_R: begin
                    if (phase_cnt != '1)
                        phase_cnt <= phase_cnt + 3'd1;
                    // Slot k lands RD_LAT cycles after the buffer's (k+1)-th read strobe.
                    for (int k = 0; k < VEC_LEN; k++)
                        if (phase_cnt == 3'(1 + k + RD_LAT))
                            out_vec[k*DATA_WIDTH +: DATA_WIDTH] <= bus.buf_rdata;
                    if (state == READ && phase_cnt == 3'(VEC_LEN - 1))
                        state <= WAIT_R;
                    if (state == WAIT_R && phase_cnt >= LAST_SLOT && bus.buf_done_read) begin
                        state              <= PRESENT;
                        bus.buf_start_read <= 1'b0;
                        out_valid          <= 1'b1;
                        vec_count          <= vec_count - 3'd1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_buffer_ctrl.sv
// Directed bench: lane 0 runs the RD_LAT=1 build, lane 1 the RD_LAT=0 build, each against a buffer model.
module tb_vector_buffer_ctrl;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0]   e0;
        logic [DW-1:0]   e1;
        logic [DW-1:0]   e2;
        logic [3*DW-1:0] exp_vec;
    } vec_case_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            in_valid  [2];
    logic [DW-1:0]   in_data   [2];
    logic            out_ready [2];
    logic            in_ready  [2];
    logic            out_valid [2];
    logic [3*DW-1:0] out_vec   [2];
    logic [2:0]      vec_count [2];
    logic            sw        [2];
    logic            sr        [2];
    logic [DW-1:0]   wd        [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : lane
        vector_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

        vector_buffer_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (4),
            .RD_LAT     ((g == 0) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_vec   (out_vec[g]),
            .bus       (bus),
            .vec_count (vec_count[g])
        );

        // Buffer model: samples A_i on the three cycles after start_write rises, raises done_load
        // after the third, strobes three reads after start_read rises; done clears one cycle after start falls.
        logic [DW-1:0] mem [16];
        logic [3:0]    wp, rp;
        logic [2:0]    wc, rc;
        logic [DW-1:0] rdata_q;

        assign bus.buf_rdata = (g == 0) ? rdata_q : mem[rp];
        assign sw[g] = bus.buf_start_write;
        assign sr[g] = bus.buf_start_read;
        assign wd[g] = bus.buf_wdata;

        always @(posedge clk) begin
            if (reset) begin
                wc <= '0; rc <= '0; wp <= '0; rp <= '0; rdata_q <= '0;
                bus.buf_done_load <= 1'b0;
                bus.buf_done_read <= 1'b0;
            end else begin
                if (bus.buf_start_write) begin
                    if (wc >= 3'd1 && wc <= 3'd3) begin
                        mem[wp] <= bus.buf_wdata;
                        wp      <= wp + 4'd1;
                    end
                    if (wc == 3'd3) bus.buf_done_load <= 1'b1;
                    if (wc != 3'd7) wc <= wc + 3'd1;
                end else begin
                    wc <= '0;
                    bus.buf_done_load <= 1'b0;
                end
                if (bus.buf_start_read) begin
                    if (rc >= 3'd1 && rc <= 3'd3) begin
                        rdata_q <= mem[rp];
                        rp      <= rp + 4'd1;
                    end
                    if (rc == 3'd2) bus.buf_done_read <= 1'b1;
                    if (rc != 3'd7) rc <= rc + 3'd1;
                end else begin
                    rc <= '0;
                    bus.buf_done_read <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_vec(input int l, input logic [DW-1:0] e0, e1, e2);
        logic [DW-1:0] el [3];
        int waits;
        el = '{e0, e1, e2};
        for (int k = 0; k < 3; k++) begin
            waits = 0;
            in_valid[l] = 1'b1;
            in_data[l]  = el[k];
            while (!in_ready[l] && waits < 100) begin
                tick();
                waits++;
            end
            if (!in_ready[l]) check($sformatf("push lane%0d beat%0d accepted", l, k), 64'(in_ready[l]), 1);
            tick();
        end
        in_valid[l] = 1'b0;
    endtask

    task automatic wait_valid(input int l, input string name);
        int n = 0;
        while (!out_valid[l] && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid[l]) check({name, " out_valid timeout"}, 64'(out_valid[l]), 1);
    endtask

    task automatic wait_count(input int l, input logic [2:0] v, input string name);
        int n = 0;
        while (vec_count[l] != v && n < 60) begin
            tick();
            n++;
        end
        if (vec_count[l] != v) check({name, " vec_count timeout"}, 64'(vec_count[l]), 64'(v));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, 64'(out_valid[0]), 0);
        check({tag, " out_vec"},   64'(out_vec[0]),   0);
        check({tag, " in_ready"},  64'(in_ready[0]),  1);
        check({tag, " start_w"},   64'(sw[0]),        0);
        check({tag, " start_r"},   64'(sr[0]),        0);
        check({tag, " wdata"},     64'(wd[0]),        0);
        check({tag, " vec_count"}, 64'(vec_count[0]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_case_t rt_tbl [3];
        vec_case_t fill_tbl [6];
        bit viol;

        rt_tbl[0] = '{16'hFFFF, 16'h0000, 16'h8001, 48'h8001_0000_FFFF};
        rt_tbl[1] = '{16'h1234, 16'h5678, 16'h9ABC, 48'h9ABC_5678_1234};
        rt_tbl[2] = '{16'h00FF, 16'hFF00, 16'h0F0F, 48'h0F0F_FF00_00FF};

        fill_tbl[0] = '{16'h1010, 16'h1011, 16'h1012, 48'h1012_1011_1010};
        fill_tbl[1] = '{16'h2020, 16'h2021, 16'h2022, 48'h2022_2021_2020};
        fill_tbl[2] = '{16'h3030, 16'h3031, 16'h3032, 48'h3032_3031_3030};
        fill_tbl[3] = '{16'h4040, 16'h4041, 16'h4042, 48'h4042_4041_4040};
        fill_tbl[4] = '{16'h5050, 16'h5051, 16'h5052, 48'h5052_5051_5050};
        fill_tbl[5] = '{16'h6060, 16'h6061, 16'h6062, 48'h6062_6061_6060};

        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            in_valid[l] = 1'b0; in_data[l] = '0; out_ready[l] = 1'b0;
        end
        tick(3);
        check_reset_state("reset");
        check("reset lane1 vec_count", 64'(vec_count[1]), 0);
        reset = 1'b0;
        tick();

        // Single vector with exact handshake timing.
        push_vec(0, 16'h0001, 16'h0002, 16'h0003);
        check("sv idle before write", 64'(sw[0]), 0);
        tick(); check("sv write entry", 64'(sw[0]), 1);
        tick(); check("sv wdata e0", 64'(wd[0]), 16'h0001);
        tick(); check("sv wdata e1", 64'(wd[0]), 16'h0002);
        tick(); check("sv wdata e2", 64'(wd[0]), 16'h0003);
        tick(); check("sv start_w held T+4", 64'(sw[0]), 1);
        check("sv count before done", 64'(vec_count[0]), 0);
        tick(); check("sv start_w drop T+5", 64'(sw[0]), 0);
        check("sv count incr", 64'(vec_count[0]), 1);
        tick();
        out_ready[0] = 1'b1;
        tick(); check("sv read entry", 64'(sr[0]), 1);
        tick(4); check("sv out_valid not early", 64'(out_valid[0]), 0);
        tick(); check("sv out_valid", 64'(out_valid[0]), 1);
        check("sv out_vec", out_vec[0], 48'h0003_0002_0001);
        check("sv count decr", 64'(vec_count[0]), 0);
        check("sv start_r dropped", 64'(sr[0]), 0);
        tick(); out_ready[0] = 1'b0;
        check("sv out_valid cleared", 64'(out_valid[0]), 0);
        tick(); check("sv no read at empty", 64'(sr[0]), 0);

        // Table-driven round trips.
        for (int i = 0; i < 3; i++) begin
            push_vec(0, rt_tbl[i].e0, rt_tbl[i].e1, rt_tbl[i].e2);
            wait_count(0, 3'd1, $sformatf("rt%0d", i));
            out_ready[0] = 1'b1;
            wait_valid(0, $sformatf("rt%0d", i));
            check($sformatf("rt%0d out_vec", i), out_vec[0], rt_tbl[i].exp_vec);
            check($sformatf("rt%0d count", i), 64'(vec_count[0]), 0);
            tick();
            out_ready[0] = 1'b0;
        end

        // Fill to MAX_VECS: the sixth vector parks in the collector.
        for (int i = 0; i < 6; i++)
            push_vec(0, fill_tbl[i].e0, fill_tbl[i].e1, fill_tbl[i].e2);
        wait_count(0, 3'd5, "fill");
        viol = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vec_count[0] == 3'd5 && sw[0]) viol = 1'b1;
        end
        check("fill count saturates", 64'(vec_count[0]), 5);
        check("fill in_ready low", 64'(in_ready[0]), 0);
        check("fill no write at max", 64'(viol), 0);

        // Backpressure: out_ready pulses only to start the read, then stays low in PRESENT.
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("bp read start", 64'(sr[0]), 1);
        wait_valid(0, "bp");
        check("bp out_vec", out_vec[0], fill_tbl[0].exp_vec);
        check("bp count", 64'(vec_count[0]), 4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp hold vec c%0d", i), out_vec[0], fill_tbl[0].exp_vec);
            check($sformatf("bp hold valid c%0d", i), 64'(out_valid[0]), 1);
            check($sformatf("bp no read c%0d", i), 64'(sr[0]), 0);
        end

        // Continuous demand drains in FIFO order down to two held vectors.
        out_ready[0] = 1'b1;
        for (int j = 1; j < 3; j++) begin
            tick();
            wait_valid(0, $sformatf("drain%0d", j));
            check($sformatf("drain%0d out_vec", j), out_vec[0], fill_tbl[j].exp_vec);
        end
        check("sim count 2", 64'(vec_count[0]), 2);
        // full=1, out_ready=1, vec_count=2 in the next IDLE: read must win.
        tick();
        check("sim idle no read", 64'(sr[0]), 0);
        check("sim idle no write", 64'(sw[0]), 0);
        tick();
        check("sim read first", 64'(sr[0]), 1);
        check("sim write held off", 64'(sw[0]), 0);
        out_ready[0] = 1'b0;
        wait_valid(0, "sim");
        check("sim out_vec", out_vec[0], fill_tbl[3].exp_vec);
        check("sim count 1", 64'(vec_count[0]), 1);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("sim idle gap", 64'(sw[0]), 0);
        tick();
        check("sim write follows", 64'(sw[0]), 1);
        wait_count(0, 3'd2, "sim write");

        // Reset during WRITE, with a stray beat collected in between.
        push_vec(0, 16'h7001, 16'h7002, 16'h7003);
        tick();
        check("rst write entry", 64'(sw[0]), 1);
        in_valid[0] = 1'b1;
        in_data[0]  = 16'hDEAD;
        tick();
        in_valid[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("mid-write reset");
        reset = 1'b0;
        tick();
        push_vec(0, 16'hA5A5, 16'h5A5A, 16'h0F0F);
        wait_count(0, 3'd1, "post-reset");
        out_ready[0] = 1'b1;
        wait_valid(0, "post-reset");
        check("post-reset out_vec", out_vec[0], 48'h0F0F_5A5A_A5A5);
        check("post-reset count", 64'(vec_count[0]), 0);
        tick();
        out_ready[0] = 1'b0;

        // RD_LAT=0 build: same single vector, one cycle less read latency.
        push_vec(1, 16'h0001, 16'h0002, 16'h0003);
        wait_count(1, 3'd1, "lat0");
        tick();
        out_ready[1] = 1'b1;
        tick(4);
        check("lat0 out_valid not early", 64'(out_valid[1]), 0);
        tick();
        check("lat0 out_valid", 64'(out_valid[1]), 1);
        check("lat0 out_vec", out_vec[1], 48'h0003_0002_0001);
        check("lat0 count", 64'(vec_count[1]), 0);
        tick();
        out_ready[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_buffer_ctrl.md
# vector_buffer_ctrl

Initiator-side sequencer for the three-element vector buffer in the QR datapath. It collects one 3-element column vector from an upstream valid/ready stream and writes it into the buffer with the start_write/done_load handshake. On downstream demand it reads one vector back with the start_read/done_read_vector handshake and presents it as a packed word. It also tracks how many vectors the buffer currently holds.

## Interface
- DATA_WIDTH, 16, element width; must match the buffer instance
- ADDR_WIDTH, 4, buffer FIFO address width; MAX_VECS = (2**ADDR_WIDTH)/3 (5 at default)
- RD_LAT, 1, cycles from buffer read strobe to element valid on the buffer output (0 or 1)
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1 / 1  upstream element handshake; beat on in_valid && in_ready
- in_data  in  DATA_WIDTH  upstream element; element 0 first
- out_valid / out_ready  out / in  1 / 1  downstream vector handshake
- out_vec  out  3*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- buf_start_write  out  1  to buffer start_write
- buf_wdata  out  DATA_WIDTH  to buffer A_i
- buf_done_load  in  1  from buffer done_load
- buf_start_read  out  1  to buffer start_read
- buf_rdata  in  DATA_WIDTH  from buffer A_o
- buf_done_read  in  1  from buffer done_read_vector
- vec_count  out  3  vectors held in buffer

## Operation
- States: IDLE, WRITE, WAIT_W, READ, WAIT_R, PRESENT.
- Collect stage runs independently of the FSM:
  - 3 element registers plus a 2-bit beat counter and a `full` flag.
  - in_ready = !full. The third beat sets full.
  - full clears on the cycle WRITE is entered.
- IDLE transitions:
  - Go to READ if vec_count > 0 and out_ready. Read has priority.
  - Otherwise go to WRITE if full and vec_count < MAX_VECS.
  - Otherwise stay in IDLE.
- WRITE:
  - Drive buf_start_write = 1.
  - Drive element k on buf_wdata in the k-th cycle after entry (k = 0..2).
  - After the third element, go to WAIT_W.
- WAIT_W:
  - Hold buf_start_write = 1 until buf_done_load = 1.
  - Then go to IDLE and increment vec_count.
- READ / WAIT_R:
  - Drive buf_start_read = 1.
  - Capture buf_rdata into out_vec slot k in cycle 1+k+RD_LAT after READ entry.
  - Once slot 2 is captured and buf_done_read = 1, go to PRESENT and decrement vec_count.
- PRESENT:
  - Drive out_valid = 1 and hold out_vec stable.
  - On out_ready, go to IDLE.
- buf_start_write and buf_start_read are never high together.
- vec_count saturates logically: no write when it equals MAX_VECS, no read when it is 0.

## Timing
- All outputs are registered.
- Reset values:
  - out_valid = 0, out_vec = 0, in_ready = 1.
  - buf_start_write = 0, buf_start_read = 0, buf_wdata = 0.
  - vec_count = 0, state = IDLE.
  - Collect counter and full flag cleared.
- Write handshake, with WRITE entered at cycle T:
  - buf_wdata carries elements 0, 1, 2 at T+1, T+2, T+3.
  - buf_done_load is expected at T+4.
  - buf_start_write drops at T+5.
- Read handshake, with READ entered at cycle R:
  - Buffer read strobes occur at R+1..R+3.
  - buf_done_read is expected from R+3.
  - buf_start_read drops on the cycle after done is seen.
- done inputs are ignored in the first cycle of a phase, because the buffer clears done one cycle after start falls.
- Minimum one IDLE cycle between phases.
- Minimum latencies:
  - Third upstream beat to vec_count increment: 6 cycles.
  - IDLE with out_ready to out_valid: 5 cycles (RD_LAT = 1).
- Upstream beats are accepted during any state, including WRITE: full clears at WRITE entry, so the next vector can start loading.
- Collecting a vector while vec_count = MAX_VECS:
  - full stays set and in_ready = 0.
  - No data is dropped.
- out_ready low in PRESENT: hold out_valid and out_vec indefinitely.
- Reset mid-phase:
  - Everything returns to reset values and the partially collected vector is discarded.
  - The buffer shares this reset, so its contents and counters are discarded too.

## Structure
- Shared package vec_buf_pkg holds:
  - the state enum typedef;
  - VEC_LEN = 3;
  - the MAX_VECS computation function.
- The collect stage is a natural sub-module: vec_collector (3-deep element gather with valid/ready, full flag, clear input).
- The buffer itself is instantiated at the parent level, not inside this block.

## Test plan
- Single vector:
  - Stimulus: push 0x0001, 0x0002, 0x0003, then raise out_ready.
  - Required: buf_wdata shows 1, 2, 3 on consecutive cycles; vec_count goes 1 then 0; out_vec = 0x0003_0002_0001 with out_valid.
- Fill to MAX_VECS:
  - Stimulus: push 6 vectors with out_ready = 0.
  - Required: vec_count stops at 5; in_ready = 0 after the 6th vector collects; no buf_start_write while vec_count = 5.
- Simultaneous demand:
  - Stimulus: full = 1 and out_ready = 1 with vec_count = 2.
  - Required: READ is entered first, and WRITE follows after one IDLE cycle.
- Backpressure:
  - Stimulus: out_ready held low for 10 cycles in PRESENT.
  - Required: out_vec is unchanged; no new read starts.
- Reset:
  - Stimulus: assert reset at T+2 of WRITE.
  - Required: all outputs at reset values the next cycle; vec_count = 0; subsequent vector round-trips correctly.
- RD_LAT = 0 build:
  - Stimulus: same as the single-vector test.
  - Required: identical out_vec.
